// File: rtl/fetch_to_control_pkg.sv
// Shared widths, instruction layout, cache address slicing and fill FSM states for the fetch front end.
// Pure declarations: no latency, no flow control.
package fetch_to_control_pkg;

  localparam int VIRT_ADDR_WIDTH   = 32;
  localparam int ICACHE_LINE_WIDTH = 128;
  localparam int ICACHE_LINES      = 4;
  localparam int INSTR_WIDTH       = 32;
  localparam int REG_COUNT         = 32;
  localparam int REG_IDX_W         = 5;
  localparam int WORDS_PER_LINE    = ICACHE_LINE_WIDTH / INSTR_WIDTH;

  localparam logic [VIRT_ADDR_WIDTH-1:0] RESET_PC = 32'h0000_1000;

  // PC = { tag | index | word select | byte offset }
  localparam int WSEL_LSB = 2;
  localparam int WSEL_W   = $clog2(WORDS_PER_LINE);
  localparam int IDX_LSB  = WSEL_LSB + WSEL_W;
  localparam int IDX_W    = $clog2(ICACHE_LINES);
  localparam int TAG_LSB  = IDX_LSB + IDX_W;
  localparam int TAG_W    = VIRT_ADDR_WIDTH - TAG_LSB;

  // Field order fixes bit positions: opcode [31:25] down to offset [9:0].
  typedef struct packed {
    logic [6:0] opcode;
    logic [4:0] dst;
    logic [4:0] src1;
    logic [4:0] src2;
    logic [9:0] offset;
  } instr_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MISS = 1'b1
  } icache_state_t;

  function automatic logic [WSEL_W-1:0] pc_wsel(input logic [VIRT_ADDR_WIDTH-1:0] pc);
    return pc[WSEL_LSB +: WSEL_W];
  endfunction

  function automatic logic [IDX_W-1:0] pc_index(input logic [VIRT_ADDR_WIDTH-1:0] pc);
    return pc[IDX_LSB +: IDX_W];
  endfunction

  function automatic logic [TAG_W-1:0] pc_tag(input logic [VIRT_ADDR_WIDTH-1:0] pc);
    return pc[TAG_LSB +: TAG_W];
  endfunction

endpackage

// File: rtl/fetch_to_control_icache.sv
// Direct-mapped instruction cache with a single-line fill FSM; hits return the word combinationally.
// Miss costs one edge to enter MISS plus the wait for mem_data_rdy; stall stays high until the line is present.
module fc_icache
  import fetch_to_control_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [VIRT_ADDR_WIDTH-1:0]   pc,
  input  logic                         flush,
  input  logic                         mem_data_rdy,
  input  logic [ICACHE_LINE_WIDTH-1:0] instr_from_mem,
  output logic [INSTR_WIDTH-1:0]       instr,
  output logic                         hit,
  output logic                         stall
);

  logic [ICACHE_LINE_WIDTH-1:0] data_q [ICACHE_LINES];
  logic [TAG_W-1:0]             tag_q  [ICACHE_LINES];
  logic [ICACHE_LINES-1:0]      valid_q;

  icache_state_t state_q, state_nxt;
  logic          fill;
  logic          tag_match;

  logic [IDX_W-1:0]                                 idx;
  logic [WORDS_PER_LINE-1:0][INSTR_WIDTH-1:0]       line_words;
  logic [1:0]                                       unused_pc_lsb;

  assign idx           = pc_index(pc);
  assign tag_match     = valid_q[idx] && (tag_q[idx] == pc_tag(pc));
  assign hit           = (state_q == ST_IDLE) && tag_match;
  assign stall         = !hit;
  assign line_words    = data_q[idx];
  assign instr         = line_words[pc_wsel(pc)];
  assign unused_pc_lsb = pc[1:0];

  // A redirect abandons the outstanding fill; the new PC is looked up fresh from IDLE.
  always_comb begin
    state_nxt = state_q;
    fill      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!flush && !tag_match) state_nxt = ST_MISS;
      end
      ST_MISS: begin
        if (flush) begin
          state_nxt = ST_IDLE;
        end else if (mem_data_rdy) begin
          fill      = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      valid_q <= '0;
      for (int i = 0; i < ICACHE_LINES; i++) tag_q[i] <= '0;
    end else begin
      state_q <= state_nxt;
      if (fill) begin
        valid_q[idx] <= 1'b1;
        tag_q[idx]   <= pc_tag(pc);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (fill) data_q[idx] <= instr_from_mem;
  end

endmodule

// File: rtl/fetch_to_control.sv
// PC, I-cache, IF/ID register, decode and register-file read feeding the execute stage.
// Hit word reaches the outputs one edge after fetch; wrt_en=0 freezes PC/IR, misses insert bubbles.
module fetch_to_control
  import fetch_to_control_pkg::*;
(
  input  logic                         clk,
  input  logic                         reset,
  input  logic [VIRT_ADDR_WIDTH-1:0]   PCbranch,
  input  logic                         branch_hit,
  input  logic                         wrt_en,
  input  logic [ICACHE_LINE_WIDTH-1:0] instr_from_mem,
  input  logic                         mem_data_rdy,
  input  logic                         data_filled_ack,
  output logic [31:0]                  regDdata,
  output logic [31:0]                  regBdata,
  output logic                         zero,
  output logic [REG_IDX_W-1:0]         regD
);

  logic [VIRT_ADDR_WIDTH-1:0] pc;
  instr_t                     ir;
  logic                       ir_vld;
  logic [INSTR_WIDTH-1:0]     fetch_word;
  logic                       fetch_hit;
  logic                       fetch_stall;
  logic                       flush;

  logic [31:0] rf [REG_COUNT];
  logic [31:0] src1_val, src2_val, dst_val;
  logic        unused_ok;

  assign flush = branch_hit && wrt_en;

  fc_icache u_icache (
    .clk            (clk),
    .rst_n          (reset),
    .pc             (pc),
    .flush          (flush),
    .mem_data_rdy   (mem_data_rdy),
    .instr_from_mem (instr_from_mem),
    .instr          (fetch_word),
    .hit            (fetch_hit),
    .stall          (fetch_stall)
  );

  // Redirect wins over a same-cycle hit so the wrong-path word never reaches IR.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc     <= RESET_PC;
      ir     <= '0;
      ir_vld <= 1'b0;
    end else if (wrt_en) begin
      if (branch_hit) begin
        pc     <= {PCbranch[VIRT_ADDR_WIDTH-1:2], 2'b00};
        ir_vld <= 1'b0;
      end else if (fetch_hit) begin
        ir     <= instr_t'(fetch_word);
        ir_vld <= 1'b1;
        pc     <= pc + VIRT_ADDR_WIDTH'(4);
      end else begin
        ir_vld <= 1'b0;
      end
    end
  end

  // No write port yet: contents are the identity pattern loaded at reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < REG_COUNT; i++) rf[i] <= 32'(i);
    end
  end

  assign src1_val = (ir.src1 == '0) ? 32'd0 : rf[ir.src1];
  assign src2_val = (ir.src2 == '0) ? 32'd0 : rf[ir.src2];
  assign dst_val  = (ir.dst  == '0) ? 32'd0 : rf[ir.dst];

  assign regD     = ir_vld ? ir.dst   : '0;
  assign regDdata = ir_vld ? dst_val  : 32'd0;
  assign regBdata = ir_vld ? src2_val : 32'd0;
  assign zero     = ir_vld && (src1_val == src2_val);

  assign unused_ok = &{1'b0, ir.opcode, ir.offset, data_filled_ack, PCbranch[1:0], fetch_stall};

endmodule

// File: tb/tb_fetch_to_control.sv
// Directed bench for fetch_to_control: reset, cold miss, miss wait, stall, branch and async reset mid-miss.
module tb_fetch_to_control;
  import fetch_to_control_pkg::*;

  logic         clk = 1'b0;
  logic         reset;
  logic [31:0]  PCbranch;
  logic         branch_hit;
  logic         wrt_en;
  logic [127:0] instr_from_mem;
  logic         mem_data_rdy;
  logic         data_filled_ack;
  logic [31:0]  regDdata;
  logic [31:0]  regBdata;
  logic         zero;
  logic [4:0]   regD;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fetch_to_control dut (
    .clk             (clk),
    .reset           (reset),
    .PCbranch        (PCbranch),
    .branch_hit      (branch_hit),
    .wrt_en          (wrt_en),
    .instr_from_mem  (instr_from_mem),
    .mem_data_rdy    (mem_data_rdy),
    .data_filled_ack (data_filled_ack),
    .regDdata        (regDdata),
    .regBdata        (regBdata),
    .zero            (zero),
    .regD            (regD)
  );

  // Observed outputs packed as {regD, regDdata, regBdata, zero}.
  logic [69:0] obs;
  assign obs = {regD, regDdata, regBdata, zero};

  function automatic logic [69:0] mk(input int d, input int dd, input int b, input bit z);
    return {5'(d), 32'(dd), 32'(b), z};
  endfunction

  localparam logic [31:0]  I_ADD = 32'h0030_8800;  // r3 <- r1,r2
  localparam logic [31:0]  I_B0  = 32'h0063_A000;  // dst6 src1=7 src2=8
  localparam logic [31:0]  I_B1  = 32'h0052_1000;  // dst5 src1=4 src2=4
  localparam logic [31:0]  I_B2  = 32'h0090_0000;  // dst9 src1=0 src2=0
  localparam logic [31:0]  I_B3  = 32'h01F0_7C00;  // dst31 src1=0 src2=31
  localparam logic [31:0]  I_C3  = 32'h0021_0C00;  // dst2 src1=2 src2=3
  localparam logic [127:0] LINE_A = {I_ADD, I_ADD, I_ADD, I_ADD};
  localparam logic [127:0] LINE_B = {I_B3, I_B2, I_B1, I_B0};
  localparam logic [127:0] LINE_C = {I_C3, I_B2, I_B1, I_B0};

  logic [69:0] O_NONE, O_ADD, O_B0, O_B1, O_B2, O_C3;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #27;
    n_checks++;
    if (obs !== O_NONE) begin n_fail++; $display("FAIL reset_outputs: got %h expected %h", obs, O_NONE); end
    n_checks++;
    if (dut.pc !== 32'h0000_1000) begin n_fail++; $display("FAIL reset_pc: got %h expected %h", dut.pc, 32'h1000); end
    n_checks++;
    if (dut.u_icache.valid_q !== 4'b0000) begin n_fail++; $display("FAIL reset_no_fill: got %b expected 0000", dut.u_icache.valid_q); end
    n_checks++;
    if (dut.u_icache.state_q !== ST_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d expected %0d", dut.u_icache.state_q, ST_IDLE); end
    #3;
    reset = 1'b1;
  endtask

  task automatic test_cold_miss;
    logic [69:0] exp_o  [6];
    logic [31:0] exp_pc [6];
    exp_o  = '{O_NONE, O_NONE, O_ADD, O_ADD, O_ADD, O_ADD};
    exp_pc = '{32'h1000, 32'h1000, 32'h1004, 32'h1008, 32'h100C, 32'h1010};
    for (int e = 0; e < 6; e++) begin
      tick();
      n_checks++;
      if (obs !== exp_o[e]) begin n_fail++; $display("FAIL cold_out_e%0d: got %h expected %h", e + 1, obs, exp_o[e]); end
      n_checks++;
      if (dut.pc !== exp_pc[e]) begin n_fail++; $display("FAIL cold_pc_e%0d: got %h expected %h", e + 1, dut.pc, exp_pc[e]); end
    end
    mem_data_rdy   = 1'b0;
    instr_from_mem = LINE_B;
  endtask

  task automatic test_miss_wait;
    for (int e = 0; e < 6; e++) begin
      tick();
      n_checks++;
      if (dut.u_icache.state_q !== ST_MISS) begin n_fail++; $display("FAIL wait_state_%0d: got %0d expected %0d", e, dut.u_icache.state_q, ST_MISS); end
      n_checks++;
      if (obs !== O_NONE || dut.pc !== 32'h1010) begin n_fail++; $display("FAIL wait_bubble_%0d: got %h pc %h expected %h pc 1010", e, obs, dut.pc, O_NONE); end
    end
    mem_data_rdy = 1'b1;
    tick();
    mem_data_rdy = 1'b0;
    n_checks++;
    if (dut.u_icache.state_q !== ST_IDLE || obs !== O_NONE) begin n_fail++; $display("FAIL wait_fill: got state %0d out %h expected IDLE and %h", dut.u_icache.state_q, obs, O_NONE); end
    tick();
    n_checks++;
    if (obs !== O_B0 || dut.pc !== 32'h1014) begin n_fail++; $display("FAIL wait_load: got %h pc %h expected %h pc 1014", obs, dut.pc, O_B0); end
  endtask

  task automatic test_stall;
    wrt_en = 1'b0;
    for (int e = 0; e < 3; e++) begin
      tick();
      n_checks++;
      if (obs !== O_B0 || dut.pc !== 32'h1014) begin n_fail++; $display("FAIL stall_%0d: got %h pc %h expected %h pc 1014", e, obs, dut.pc, O_B0); end
    end
    wrt_en = 1'b1;
    tick();
    n_checks++;
    if (obs !== O_B1 || dut.pc !== 32'h1018) begin n_fail++; $display("FAIL stall_resume_zero: got %h pc %h expected %h pc 1018", obs, dut.pc, O_B1); end
    tick();
    n_checks++;
    if (obs !== O_B2 || dut.pc !== 32'h101C) begin n_fail++; $display("FAIL stall_resume_r0: got %h pc %h expected %h pc 101c", obs, dut.pc, O_B2); end
  endtask

  task automatic test_branch;
    branch_hit = 1'b1;
    PCbranch   = 32'h0000_11FF;
    tick();
    branch_hit = 1'b0;
    n_checks++;
    if (obs !== O_NONE || dut.pc !== 32'h11FC) begin n_fail++; $display("FAIL branch_redirect: got %h pc %h expected %h pc 11fc", obs, dut.pc, O_NONE); end
    instr_from_mem = LINE_C;
    mem_data_rdy   = 1'b1;
    tick();
    n_checks++;
    if (dut.u_icache.state_q !== ST_MISS || obs !== O_NONE) begin n_fail++; $display("FAIL branch_miss: got state %0d out %h expected MISS and %h", dut.u_icache.state_q, obs, O_NONE); end
    tick();
    mem_data_rdy = 1'b0;
    n_checks++;
    if (dut.u_icache.valid_q !== 4'b1011) begin n_fail++; $display("FAIL branch_fill_valid: got %b expected 1011", dut.u_icache.valid_q); end
    tick();
    n_checks++;
    if (obs !== O_C3 || dut.pc !== 32'h1200) begin n_fail++; $display("FAIL branch_target_word: got %h pc %h expected %h pc 1200", obs, dut.pc, O_C3); end
  endtask

  task automatic test_branch_abandon;
    tick();
    n_checks++;
    if (dut.u_icache.state_q !== ST_MISS) begin n_fail++; $display("FAIL abandon_enter_miss: got %0d expected %0d", dut.u_icache.state_q, ST_MISS); end
    branch_hit = 1'b1;
    PCbranch   = 32'h0000_1008;
    tick();
    branch_hit = 1'b0;
    n_checks++;
    if (dut.u_icache.state_q !== ST_IDLE || dut.pc !== 32'h1008) begin n_fail++; $display("FAIL abandon_idle: got state %0d pc %h expected IDLE pc 1008", dut.u_icache.state_q, dut.pc); end
    tick();
    n_checks++;
    if (obs !== O_ADD || dut.pc !== 32'h100C) begin n_fail++; $display("FAIL abandon_line_kept: got %h pc %h expected %h pc 100c", obs, dut.pc, O_ADD); end
  endtask

  task automatic test_reset_mid_miss;
    branch_hit = 1'b1;
    PCbranch   = 32'h0000_1200;
    tick();
    branch_hit = 1'b0;
    tick();
    n_checks++;
    if (dut.u_icache.state_q !== ST_MISS) begin n_fail++; $display("FAIL midreset_pre_miss: got %0d expected %0d", dut.u_icache.state_q, ST_MISS); end
    #2;
    reset = 1'b0;
    #1;
    n_checks++;
    if (dut.u_icache.valid_q !== 4'b0000 || dut.u_icache.state_q !== ST_IDLE) begin n_fail++; $display("FAIL midreset_cache: got valid %b state %0d expected 0000 IDLE", dut.u_icache.valid_q, dut.u_icache.state_q); end
    n_checks++;
    if (obs !== O_NONE || dut.pc !== 32'h1000) begin n_fail++; $display("FAIL midreset_outputs: got %h pc %h expected %h pc 1000", obs, dut.pc, O_NONE); end
    #4;
    reset = 1'b1;
  endtask

  initial begin
    O_NONE = '0;
    O_ADD  = mk(3, 3, 2, 1'b0);
    O_B0   = mk(6, 6, 8, 1'b0);
    O_B1   = mk(5, 5, 4, 1'b1);
    O_B2   = mk(9, 9, 0, 1'b1);
    O_C3   = mk(2, 2, 3, 1'b0);

    reset           = 1'b0;
    wrt_en          = 1'b1;
    branch_hit      = 1'b0;
    PCbranch        = '0;
    mem_data_rdy    = 1'b1;
    instr_from_mem  = LINE_A;
    data_filled_ack = 1'b0;

    test_reset();
    test_cold_miss();
    test_miss_wait();
    test_stall();
    test_branch();
    test_branch_abandon();
    test_reset_mid_miss();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_to_control.md
# fetch_to_control

Front end of the basic in-order processor: program counter, a small direct-mapped instruction cache with a line-fill path from memory, an IF/ID instruction register, field decode and a 32×32 register file read. The outputs feed the execute/control stage: the destination index, two operand values, and an equality flag used by branch logic. Branch redirection arrives from later stages via `PCbranch`/`branch_hit`.

## Interface
- `VIRT_ADDR_WIDTH`, 32: PC and branch-target width. Set in the shared package.
- `ICACHE_LINE_WIDTH`, 128: cache line width, 4 instructions of 32 bits. Set in the shared package.
- `ICACHE_LINES`, 4: number of direct-mapped lines.
- `RESET_PC`, 32'h0000_1000: PC after reset.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low.
- `PCbranch` in VIRT_ADDR_WIDTH: branch target address.
- `branch_hit` in 1: redirect the PC to `PCbranch`.
- `wrt_en` in 1: pipeline advance enable. 0 stalls the PC and IR.
- `instr_from_mem` in ICACHE_LINE_WIDTH: fill line. Instruction k occupies bits [32k+31:32k], with k=0 at the lowest address.
- `mem_data_rdy` in 1: `instr_from_mem` is valid this cycle.
- `data_filled_ack` in 1: memory fill acknowledge. It is sampled but has no functional effect in this revision.
- `regDdata` out 32: rf[dst].
- `regBdata` out 32: rf[src2].
- `zero` out 1: high when rf[src1] == rf[src2].
- `regD` out 5: dst field.

## Operation
- Instruction fields:
  - opcode [31:25]
  - dst [24:20]
  - src1 [19:15]
  - src2 [14:10]
  - offset [9:0]
- Cache address split:
  - word select PC[3:2]
  - index PC[5:4]
  - tag PC[31:6]
  - each line holds a valid bit and a tag.
- Cache FSM, IDLE and MISS:
  - IDLE, hit: the instruction is available combinationally.
  - IDLE, miss: go to MISS.
  - MISS: on `mem_data_rdy`=1, write `instr_from_mem` into the line at the PC index, set the tag and valid bit, then return to IDLE.
  - MISS, `mem_data_rdy`=0: stay in MISS.
- Advance condition is IDLE and hit and `wrt_en`. On advance:
  - IR <= fetched word, IR valid <= 1, PC <= PC+4.
  - PC wraps modulo 2^32.
- When the advance condition is false but `wrt_en`=1 (miss in progress): IR valid <= 0, inserting a bubble.
- When `wrt_en`=0: PC, IR and IR valid hold. The fill FSM still runs.
- `branch_hit`=1 with `wrt_en`=1:
  - PC <= {PCbranch[31:2], 2'b00}.
  - IR valid <= 0, flushing the fetched instruction.
  - Any in-progress miss is abandoned and the FSM returns to IDLE.
  - Branch takes priority over a normal advance.
- Register file: 32×32, read asynchronously.
  - r0 reads 0 at all times.
  - At reset, rf[i] = i.
  - There is no write port in this revision.
- Outputs are combinational from the IR and the register file.
  - IR valid=0 forces `regD`=0, `regDdata`=0, `regBdata`=0, `zero`=0.

## Timing
- Reset asserted:
  - PC = RESET_PC, FSM = IDLE, all cache valid bits = 0, IR = 0, IR valid = 0.
  - Register file set to rf[i]=i.
  - All outputs 0.
- Hit latency: an instruction fetched on a hit at edge N appears on the outputs after edge N.
- Cold miss with `mem_data_rdy` already high, counting edges after reset release:
  - edge 1: IDLE→MISS.
  - edge 2: fill, →IDLE.
  - edge 3: IR loads.
  - Outputs are valid after edge 3.
- Next three sequential words in the same line hit back-to-back, one per cycle.
- Reset asserted mid-miss aborts the fill and invalidates all lines immediately, because reset is asynchronous.
- `mem_data_rdy` outside MISS is ignored.

## Structure
- Shared package holds:
  - `VIRT_ADDR_WIDTH`, `ICACHE_LINE_WIDTH`
  - field bit positions
  - cache index, tag and word-select slices
  - `RESET_PC`
  - FSM state encodings
- One sub-module, `fc_icache`: tag/valid/data arrays, hit compare, word select, fill FSM, with a `stall` output.
- The top level holds the PC, IR, decode and register file.

## Test plan
- Reset held low for 30 ns:
  - all outputs 0
  - PC = 0x1000
  - no fill occurs even with `mem_data_rdy`=1.
- Cold miss then hit:
  - Stimulus: reset released, `mem_data_rdy`=1, line = 4× ADD r1,r2→r3 (0x0030_8800).
  - After edge 3: `regD`=3, `regDdata`=3, `regBdata`=2, `zero`=0.
  - Three further cycles produce the same outputs.
- Stall:
  - `wrt_en`=0 for 3 cycles: PC and outputs frozen.
  - Re-enable: fetch resumes at the next word.
- Branch:
  - `branch_hit`=1, `PCbranch`=0x11FF: PC becomes 0x11FC and the next cycle's outputs are a bubble (all 0).
  - 0x11FC maps to a different tag, so it misses and a new fill follows.
- Miss wait:
  - `mem_data_rdy`=0 for 5 cycles: FSM stays in MISS and outputs are a bubble.
  - `mem_data_rdy` pulsed: the fill completes and IR loads 2 edges later.
- Zero flag: fill with an instruction using src1=src2=r4; `zero`=1.
